regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file for the pipelined RISC-V core: configurable width, depth and read-port count, one write port committing on the rising edge with write-through bypass, and an integrated busy-bit scoreboard. Decode reads operands and allocates a destination; writeback writes the result and releases it. Replaces the fixed 32x32 two-read, negedge-write file.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, >= 2)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and allocations
- AW, $clog2(NREGS), address width (derived, not overridden)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  writeback write enable
- waddr  in  AW  writeback destination
- wdata  in  XLEN  writeback data
- raddr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
- rdata  out  NRD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
- rready  out  NRD  port i operand not pending (safe to consume)
- alloc_en  in  1  decode issues an instruction writing alloc_addr
- alloc_addr  in  AW  destination being allocated
- flush  in  1  pipeline flush; clears all busy bits
- busy  out  NREGS  current busy vector, for debug and hazard unit

## Operation
- Reset (rst_n low, asynchronous): every register cleared to 0, every busy bit cleared. rdata and rready are combinational from that state: rdata = 0, rready = all ones while reset is held.
- Write: on rising edge with we=1, reg[waddr] <= wdata. With ZERO_REG=1 and waddr=0 the write is dropped.
- Read (combinational, per port i): if we=1, waddr==raddr[i] and the write is not dropped, rdata[i] = wdata (bypass); else reg[raddr[i]]. Register 0 with ZERO_REG=1 always reads 0.
- rready[i] = !busy[raddr[i]] OR (we AND waddr==raddr[i]). Register 0 with ZERO_REG=1 always ready.
- Scoreboard update at rising edge, priority low to high: (1) we=1 clears busy[waddr]; (2) flush=1 clears all busy bits; (3) alloc_en=1 sets busy[alloc_addr] (ignored for register 0 with ZERO_REG=1).
- Simultaneous we and alloc_en to the same address: busy ends set (the new producer owns the register); data is still written.
- Simultaneous flush and alloc_en: all busy bits cleared except alloc_addr, which is set.
- Allocation to an already-busy register: stays busy (no counting; single in-flight producer per register is guaranteed by the hazard unit).
- we to a non-busy register is legal; data is written, busy unchanged.

## Timing
- Read latency: 0 cycles (combinational from raddr, we, waddr, wdata and state).
- Write visible through bypass in the same cycle, from storage from the next cycle.
- alloc_en sets busy from the next cycle; a read of alloc_addr in the allocating cycle still sees the old busy state.
- flush takes effect from the next cycle.
- Reset assertion mid-operation clears state immediately regardless of clk; deassertion is synchronised externally.

## Structure
- Package rf_pkg: default XLEN and NREGS constants, helper function for packed-port slicing.
- Sub-module rf_scoreboard: NREGS busy flops with the set/clear/flush priority above; exposes busy vector. The top holds the storage array, bypass muxes and rready logic.

## Test plan
- Reset: write reg 5 = 0x1234, assert rst_n low mid-cycle -> rdata for raddr 5 becomes 0 immediately; busy = 0.
- Write/bypass: we=1, waddr=7, wdata=0xDEADBEEF, raddr[0]=7 same cycle -> rdata[0]=0xDEADBEEF; next cycle with we=0 -> still 0xDEADBEEF.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 and alloc reg 0 -> rdata=0, rready=1, busy[0]=0.
- Scoreboard: alloc reg 3 -> next cycle rready=0 for raddr 3; we to reg 3 -> rready=1 same cycle with bypass data; busy[3]=0 after edge.
- Collisions: we and alloc_en both to reg 9 -> reg 9 written, busy[9]=1 after edge; flush with alloc reg 4 while regs 2,6 busy -> busy = only bit 4.
- Parameter sweep: NREGS=16, XLEN=64, NRD=3, ZERO_REG=0 -> reg 0 writable; three ports read distinct registers simultaneously with correct data.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
package rf_pkg;

  localparam int unsigned DefaultXlen  = 32;
  localparam int unsigned DefaultNregs = 32;

  // LSB of port `port` inside a packed bus of `width`-bit lanes.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one flop per architectural register.
// Per-edge order is clear on writeback, then flush, then set on allocation.
module rf_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             flush,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             set_drop;

  // Register 0 is hardwired, so it can never have a pending producer.
  assign set_drop = ZERO_REG && (set_addr == '0);

  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end
    if (set_en && !set_drop) begin
      busy_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with write-through bypass and a busy-bit scoreboard.
// Reads are combinational; the single write port commits on the rising edge.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int unsigned  XLEN     = DefaultXlen,
  parameter int unsigned  NREGS    = DefaultNregs,
  parameter int unsigned  NRD      = 2,
  parameter bit           ZERO_REG = 1'b1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rready,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_drop;
  logic            wr_eff;

  assign wr_drop = ZERO_REG && (waddr == '0);
  assign wr_eff  = we && !wr_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (wr_eff) begin
      regs_q[waddr] <= wdata;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (we),
    .clr_addr (waddr),
    .flush    (flush),
    .set_en   (alloc_en),
    .set_addr (alloc_addr),
    .busy     (busy)
  );

  // A matching writeback both forwards its data and satisfies the pending operand.
  always_comb begin
    logic [AW-1:0] ra;
    rdata  = '0;
    rready = '0;
    ra     = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra = raddr[port_lsb(i, AW) +: AW];
      if (ZERO_REG && (ra == '0)) begin
        rdata[port_lsb(i, XLEN) +: XLEN] = '0;
        rready[i]                        = 1'b1;
      end else if (wr_eff && (waddr == ra)) begin
        rdata[port_lsb(i, XLEN) +: XLEN] = wdata;
        rready[i]                        = 1'b1;
      end else begin
        rdata[port_lsb(i, XLEN) +: XLEN] = regs_q[ra];
        rready[i]                        = !busy[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32/2-port instance plus a 16x64/3-port instance.
module tb_regfile_sb;

  logic clk;
  logic rst_n;

  // Default instance.
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [9:0]   raddr;
  logic [63:0]  rdata;
  logic [1:0]   rready;
  logic         alloc_en;
  logic [4:0]   alloc_addr;
  logic         flush;
  logic [31:0]  busy;

  // Parameter-sweep instance.
  logic         p_we;
  logic [3:0]   p_waddr;
  logic [63:0]  p_wdata;
  logic [11:0]  p_raddr;
  logic [191:0] p_rdata;
  logic [2:0]   p_rready;
  logic         p_alloc_en;
  logic [3:0]   p_alloc_addr;
  logic         p_flush;
  logic [15:0]  p_busy;

  int vectors;
  int miscompares;

  regfile_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .rready     (rready),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy       (busy)
  );

  regfile_sb #(
    .XLEN     (64),
    .NREGS    (16),
    .NRD      (3),
    .ZERO_REG (1'b0)
  ) dut_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (p_we),
    .waddr      (p_waddr),
    .wdata      (p_wdata),
    .raddr      (p_raddr),
    .rdata      (p_rdata),
    .rready     (p_rready),
    .alloc_en   (p_alloc_en),
    .alloc_addr (p_alloc_addr),
    .flush      (p_flush),
    .busy       (p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    p_we = 1'b0; p_waddr = '0; p_wdata = '0; p_alloc_en = 1'b0; p_alloc_addr = '0;
    p_flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    raddr = {5'd0, 5'd5};
    p_raddr = '0;
    rst_n = 1'b0;
    #3;
    vectors++;
    if (rdata !== 64'h0) begin
      $display("FAIL reset_rdata: got %h want %h", rdata, 64'h0); miscompares++;
    end
    vectors++;
    if (rready !== 2'b11) begin
      $display("FAIL reset_rready: got %b want %b", rready, 2'b11); miscompares++;
    end
    vectors++;
    if (busy !== 32'h0) begin
      $display("FAIL reset_busy: got %h want %h", busy, 32'h0); miscompares++;
    end
    step();
    rst_n = 1'b1;
    step();
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234; alloc_en = 1'b1; alloc_addr = 5'd8;
    step();
    idle_inputs();
    #1;
    vectors++;
    if (rdata[31:0] !== 32'h1234) begin
      $display("FAIL pre_reset_rdata: got %h want %h", rdata[31:0], 32'h1234); miscompares++;
    end
    vectors++;
    if (busy !== 32'h0000_0100) begin
      $display("FAIL pre_reset_busy: got %h want %h", busy, 32'h0000_0100); miscompares++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rdata[31:0] !== 32'h0) begin
      $display("FAIL async_reset_rdata: got %h want %h", rdata[31:0], 32'h0); miscompares++;
    end
    vectors++;
    if (busy !== 32'h0) begin
      $display("FAIL async_reset_busy: got %h want %h", busy, 32'h0); miscompares++;
    end
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF; raddr = {5'd5, 5'd7};
    #1;
    vectors++;
    if (rdata !== {32'h0, 32'hDEAD_BEEF}) begin
      $display("FAIL bypass_rdata: got %h want %h", rdata, {32'h0, 32'hDEAD_BEEF});
      miscompares++;
    end
    step();
    idle_inputs();
    #1;
    vectors++;
    if (rdata[31:0] !== 32'hDEAD_BEEF) begin
      $display("FAIL stored_rdata: got %h want %h", rdata[31:0], 32'hDEAD_BEEF); miscompares++;
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; alloc_en = 1'b1; alloc_addr = 5'd0;
    raddr = {5'd7, 5'd0};
    #1;
    vectors++;
    if (rdata[31:0] !== 32'h0 || rready[0] !== 1'b1) begin
      $display("FAIL zero_same_cycle: got rdata %h rready %b want 0 1", rdata[31:0], rready[0]);
      miscompares++;
    end
    step();
    idle_inputs();
    #1;
    vectors++;
    if (rdata[31:0] !== 32'h0 || rready[0] !== 1'b1 || busy !== 32'h0) begin
      $display("FAIL zero_after_edge: got rdata %h rready %b busy %h want 0 1 0",
               rdata[31:0], rready[0], busy);
      miscompares++;
    end
  endtask

  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_addr = 5'd3; raddr = {5'd7, 5'd3};
    #1;
    vectors++;
    if (rready !== 2'b11) begin
      $display("FAIL alloc_same_cycle_rready: got %b want %b", rready, 2'b11); miscompares++;
    end
    step();
    idle_inputs();
    #1;
    vectors++;
    if (rready !== 2'b10 || busy !== 32'h0000_0008) begin
      $display("FAIL alloc_pending: got rready %b busy %h want 10 00000008", rready, busy);
      miscompares++;
    end
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_0003;
    #1;
    vectors++;
    if (rready[0] !== 1'b1 || rdata[31:0] !== 32'hA5A5_0003) begin
      $display("FAIL writeback_bypass: got rready %b rdata %h want 1 a5a50003",
               rready[0], rdata[31:0]);
      miscompares++;
    end
    step();
    idle_inputs();
    #1;
    vectors++;
    if (busy !== 32'h0 || rready !== 2'b11 || rdata[31:0] !== 32'hA5A5_0003) begin
      $display("FAIL writeback_release: got busy %h rready %b rdata %h want 0 11 a5a50003",
               busy, rready, rdata[31:0]);
      miscompares++;
    end
  endtask

  task automatic test_collisions();
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_9999; alloc_en = 1'b1; alloc_addr = 5'd9;
    raddr = {5'd7, 5'd9};
    step();
    idle_inputs();
    #1;
    vectors++;
    if (rdata[31:0] !== 32'h9999 || busy !== 32'h0000_0200 || rready[0] !== 1'b0) begin
      $display("FAIL we_alloc_same_reg: got rdata %h busy %h rready %b want 9999 00000200 0",
               rdata[31:0], busy, rready[0]);
      miscompares++;
    end
    alloc_en = 1'b1; alloc_addr = 5'd2;
    step();
    alloc_addr = 5'd6;
    step();
    idle_inputs();
    #1;
    vectors++;
    if (busy !== 32'h0000_0244) begin
      $display("FAIL multi_busy: got %h want %h", busy, 32'h0000_0244); miscompares++;
    end
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd4;
    step();
    idle_inputs();
    #1;
    vectors++;
    if (busy !== 32'h0000_0010) begin
      $display("FAIL flush_alloc: got %h want %h", busy, 32'h0000_0010); miscompares++;
    end
    flush = 1'b1;
    step();
    idle_inputs();
    #1;
    vectors++;
    if (busy !== 32'h0) begin
      $display("FAIL flush_only: got %h want %h", busy, 32'h0); miscompares++;
    end
  endtask

  task automatic test_param_sweep();
    p_we = 1'b1; p_waddr = 4'd0; p_wdata = 64'h0123_4567_89AB_CDEF;
    step();
    p_waddr = 4'd5; p_wdata = 64'hFEDC_BA98_7654_3210;
    step();
    p_waddr = 4'd15; p_wdata = 64'h55AA_55AA_0F0F_F0F0;
    step();
    idle_inputs();
    p_raddr = {4'd15, 4'd5, 4'd0};
    #1;
    vectors++;
    if (p_rdata !== {64'h55AA_55AA_0F0F_F0F0, 64'hFEDC_BA98_7654_3210,
                     64'h0123_4567_89AB_CDEF}) begin
      $display("FAIL sweep_three_ports: got %h", p_rdata); miscompares++;
    end
    vectors++;
    if (p_rready !== 3'b111) begin
      $display("FAIL sweep_rready: got %b want %b", p_rready, 3'b111); miscompares++;
    end
    p_we = 1'b1; p_waddr = 4'd5; p_wdata = 64'h1111_2222_3333_4444;
    #1;
    vectors++;
    if (p_rdata[127:64] !== 64'h1111_2222_3333_4444 ||
        p_rdata[191:128] !== 64'h55AA_55AA_0F0F_F0F0) begin
      $display("FAIL sweep_bypass: got p1 %h p2 %h", p_rdata[127:64], p_rdata[191:128]);
      miscompares++;
    end
    step();
    idle_inputs();
    p_alloc_en = 1'b1; p_alloc_addr = 4'd0;
    step();
    idle_inputs();
    #1;
    vectors++;
    if (p_busy !== 16'h0001 || p_rready !== 3'b110) begin
      $display("FAIL sweep_reg0_alloc: got busy %h rready %b want 0001 110", p_busy, p_rready);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_scoreboard();
    test_collisions();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
